// File: rtl/despejo_registradores.sv
// Register-bank dump engine: streams a header byte, then every register MSB-first
// to the UART TX byte interface over a valid/ready handshake.
module despejo_registradores #(
  parameter int          NUM_REGS  = 32,
  parameter logic [7:0]  CABECALHO = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  output logic [4:0]  rs,
  input  logic [31:0] dado_rs,
  output logic [7:0]  tx_dado,
  output logic        tx_valido,
  input  logic        tx_pronto,
  output logic        ocupado,
  output logic        concluido
);

  typedef enum logic [2:0] {OCIOSO, CAB, CAPTURA, ENVIA, FIM} estado_t;

  localparam logic [4:0] ULTIMO = 5'(NUM_REGS - 1);

  estado_t     estado, estado_nxt;
  logic [4:0]  rs_nxt;
  logic [1:0]  i, i_nxt;
  logic [31:0] palavra, palavra_nxt;
  logic        transf;

  assign transf = tx_valido & tx_pronto;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= OCIOSO;
      rs      <= 5'd0;
      i       <= 2'd0;
      palavra <= 32'h0;
    end else begin
      estado  <= estado_nxt;
      rs      <= rs_nxt;
      i       <= i_nxt;
      palavra <= palavra_nxt;
    end
  end

  always_comb begin
    estado_nxt  = estado;
    rs_nxt      = rs;
    i_nxt       = i;
    palavra_nxt = palavra;
    tx_dado     = 8'h00;
    tx_valido   = 1'b0;
    ocupado     = 1'b1;
    concluido   = 1'b0;
    case (estado)
      OCIOSO: begin
        ocupado = 1'b0;
        if (iniciar) begin
          rs_nxt     = 5'd0;
          i_nxt      = 2'd0;
          estado_nxt = CAB;
        end
      end
      CAB: begin
        tx_dado   = CABECALHO;
        tx_valido = 1'b1;
        if (transf) estado_nxt = CAPTURA;
      end
      // rs has been stable since the previous transfer, so the bank read settles here
      CAPTURA: begin
        palavra_nxt = dado_rs;
        i_nxt       = 2'd0;
        estado_nxt  = ENVIA;
      end
      ENVIA: begin
        tx_valido = 1'b1;
        case (i)
          2'd0:    tx_dado = palavra[31:24];
          2'd1:    tx_dado = palavra[23:16];
          2'd2:    tx_dado = palavra[15:8];
          default: tx_dado = palavra[7:0];
        endcase
        if (transf) begin
          if (i != 2'd3) begin
            i_nxt = i + 2'd1;
          end else if (rs == ULTIMO) begin
            estado_nxt = FIM;
          end else begin
            rs_nxt     = rs + 5'd1;
            estado_nxt = CAPTURA;
          end
        end
      end
      // rs returns to 0 so the read port idles on register 0
      FIM: begin
        concluido  = 1'b1;
        rs_nxt     = 5'd0;
        estado_nxt = OCIOSO;
      end
      default: estado_nxt = OCIOSO;
    endcase
  end

endmodule
